mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-ported memory with fixed read latency.
// Alternating priority under contention; illegal fetches and protected writes complete as faults.
module mem_arbiter #(
    parameter int unsigned RD_LAT     = 1,
    parameter bit          IRAM_WR_EN = 1'b0
) (
    input  logic        clk1,
    input  logic        rst1_n,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic        f_ack,
    output logic        f_fault,
    output logic [15:0] f_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic        d_fault,
    output logic [15:0] d_rdata,
    output logic        busy,
    output logic        Write1,
    output logic [15:0] ARr1,
    output logic [15:0] Inputs1,
    input  logic [15:0] RAM
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [1:0] WaitLoad = (RD_LAT == 0) ? 2'd0 : 2'(RD_LAT - 1);

    state_t      r_state, w_state;
    logic        r_gnt_d, w_gnt_d;     // current grant: 1 = data port
    logic        r_last_d, w_last_d;   // last grant: 1 = data port
    logic        r_we, w_we;
    logic        r_fault, w_fault;
    logic [1:0]  r_cnt, w_cnt;
    logic        r_write, w_write;
    logic [15:0] r_addr, w_addr;
    logic [15:0] r_wdata, w_wdata;
    logic [15:0] r_f_rdata, w_f_rdata;
    logic [15:0] r_d_rdata, w_d_rdata;
    logic        w_f_bad, w_d_bad, w_capture;

    assign w_f_bad = (f_addr[15:10] != 6'd0);
    assign w_d_bad = d_we && !IRAM_WR_EN && (d_addr[15:10] == 6'd0);

    always_comb begin
        w_state   = r_state;
        w_gnt_d   = r_gnt_d;
        w_last_d  = r_last_d;
        w_we      = r_we;
        w_fault   = r_fault;
        w_cnt     = r_cnt;
        w_write   = 1'b0;
        w_addr    = r_addr;
        w_wdata   = r_wdata;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (f_req || d_req) begin
                    // Under contention the port that lost last time wins.
                    w_gnt_d  = d_req && (!f_req || !r_last_d);
                    w_last_d = w_gnt_d;
                    w_we     = w_gnt_d && d_we;
                    w_fault  = w_gnt_d ? w_d_bad : w_f_bad;
                    if (w_fault) begin
                        w_state = DONE;
                    end else begin
                        w_state = ISSUE;
                        w_addr  = w_gnt_d ? d_addr : f_addr;
                        w_wdata = d_wdata;
                        w_write = w_gnt_d && d_we;
                    end
                end
            end
            ISSUE: begin
                if (RD_LAT == 0) begin
                    w_state   = DONE;
                    w_capture = 1'b1;
                end else begin
                    w_state = WAIT;
                    w_cnt   = WaitLoad;
                end
            end
            WAIT: begin
                if (r_cnt == 2'd0) begin
                    w_state   = DONE;
                    w_capture = 1'b1;
                end else begin
                    w_cnt = r_cnt - 2'd1;
                end
            end
            DONE: begin
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    always_comb begin
        w_f_rdata = r_f_rdata;
        w_d_rdata = r_d_rdata;
        if (w_capture && !r_we) begin
            if (r_gnt_d) begin
                w_d_rdata = RAM;
            end else begin
                w_f_rdata = RAM;
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst1_n) begin
        if (!rst1_n) begin
            r_state   <= IDLE;
            r_gnt_d   <= 1'b0;
            r_last_d  <= 1'b1;
            r_we      <= 1'b0;
            r_fault   <= 1'b0;
            r_cnt     <= 2'd0;
            r_write   <= 1'b0;
            r_addr    <= 16'd0;
            r_wdata   <= 16'd0;
            r_f_rdata <= 16'd0;
            r_d_rdata <= 16'd0;
        end else begin
            r_state   <= w_state;
            r_gnt_d   <= w_gnt_d;
            r_last_d  <= w_last_d;
            r_we      <= w_we;
            r_fault   <= w_fault;
            r_cnt     <= w_cnt;
            r_write   <= w_write;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
            r_f_rdata <= w_f_rdata;
            r_d_rdata <= w_d_rdata;
        end
    end

    assign busy    = (r_state != IDLE);
    assign f_ack   = (r_state == DONE) && !r_gnt_d;
    assign d_ack   = (r_state == DONE) && r_gnt_d;
    assign f_fault = f_ack && r_fault;
    assign d_fault = d_ack && r_fault;
    assign f_rdata = r_f_rdata;
    assign d_rdata = r_d_rdata;
    assign Write1  = r_write;
    assign ARr1    = r_addr;
    assign Inputs1 = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (RD_LAT 0/1/3), the last allowing iram writes.
module tb_mem_arbiter;

    localparam int unsigned LAT_TAB [3] = '{0, 1, 3};

    logic        clk1;
    logic        rst1_n;
    logic [2:0]  f_req, d_req;
    logic [15:0] f_addr, d_addr, d_wdata, RAM;
    logic        d_we;
    logic [2:0]  f_ack, f_fault, d_ack, d_fault, busy, Write1;
    logic [15:0] f_rdata [3];
    logic [15:0] d_rdata [3];
    logic [15:0] ARr1 [3];
    logic [15:0] Inputs1 [3];

    int          n_vec;
    int          n_err;
    int          lat [3];
    int          n_ack;
    logic [3:0]  gorder;
    logic        both_ack;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_arbiter #(
            .RD_LAT    (LAT_TAB[g]),
            .IRAM_WR_EN(g == 2)
        ) u_dut (
            .clk1   (clk1),
            .rst1_n (rst1_n),
            .f_req  (f_req[g]),
            .f_addr (f_addr),
            .f_ack  (f_ack[g]),
            .f_fault(f_fault[g]),
            .f_rdata(f_rdata[g]),
            .d_req  (d_req[g]),
            .d_we   (d_we),
            .d_addr (d_addr),
            .d_wdata(d_wdata),
            .d_ack  (d_ack[g]),
            .d_fault(d_fault[g]),
            .d_rdata(d_rdata[g]),
            .busy   (busy[g]),
            .Write1 (Write1[g]),
            .ARr1   (ARr1[g]),
            .Inputs1(Inputs1[g]),
            .RAM    (RAM)
        );
    end

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One rising edge, then park on the falling edge to sample and drive.
    task automatic tick();
        @(posedge clk1);
        @(negedge clk1);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst1_n = 1'b1; f_req = '0; d_req = '0; d_we = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0; RAM = '0;
        #1 rst1_n = 1'b0;
        #1;
        chk("rst_busy", busy[1], 1'b0);
        chk("rst_write1", Write1[1], 1'b0);
        chk("rst_arr1", ARr1[1], 16'h0000);
        chk("rst_acks", {f_ack[1], d_ack[1], f_fault[1], d_fault[1]}, 4'h0);
        @(negedge clk1);
        rst1_n = 1'b1;

        // Fetch read, RD_LAT = 1
        f_addr = 16'h0005; RAM = 16'hA1B2; f_req[1] = 1'b1;
        tick();
        chk("fetch_issue_arr1", ARr1[1], 16'h0005);
        chk("fetch_issue_busy", busy[1], 1'b1);
        chk("fetch_issue_w1", Write1[1], 1'b0);
        chk("fetch_issue_ack", f_ack[1], 1'b0);
        tick();
        chk("fetch_wait_arr1", ARr1[1], 16'h0005);
        chk("fetch_wait_ack", f_ack[1], 1'b0);
        tick();
        chk("fetch_done_ack", f_ack[1], 1'b1);
        chk("fetch_done_fault", f_fault[1], 1'b0);
        chk("fetch_rdata", f_rdata[1], 16'hA1B2);
        f_req[1] = 1'b0;
        tick();
        chk("fetch_after_ack", f_ack[1], 1'b0);
        chk("fetch_after_busy", busy[1], 1'b0);

        // Data write outside iram
        d_addr = 16'h0800; d_wdata = 16'h00FF; d_we = 1'b1; d_req[1] = 1'b1;
        tick();
        chk("wr_issue_w1", Write1[1], 1'b1);
        chk("wr_issue_arr1", ARr1[1], 16'h0800);
        chk("wr_issue_inputs1", Inputs1[1], 16'h00FF);
        tick();
        chk("wr_wait_w1", Write1[1], 1'b0);
        tick();
        chk("wr_done_ack", d_ack[1], 1'b1);
        chk("wr_done_fault", d_fault[1], 1'b0);
        chk("wr_done_w1", Write1[1], 1'b0);
        d_req[1] = 1'b0;
        tick();

        // Reset in the middle of ISSUE of a write
        d_req[1] = 1'b1;
        tick();
        chk("rstmid_w1_before", Write1[1], 1'b1);
        #2 rst1_n = 1'b0;
        #1;
        chk("rstmid_w1", Write1[1], 1'b0);
        chk("rstmid_arr1", ARr1[1], 16'h0000);
        chk("rstmid_inputs1", Inputs1[1], 16'h0000);
        chk("rstmid_busy", busy[1], 1'b0);
        chk("rstmid_ack", d_ack[1], 1'b0);
        chk("rstmid_f_rdata", f_rdata[1], 16'h0000);
        chk("rstmid_d_rdata", d_rdata[1], 16'h0000);
        d_req[1] = 1'b0;
        @(negedge clk1);
        rst1_n = 1'b1;
        tick();
        chk("rstmid_no_ack_a", d_ack[1], 1'b0);
        tick();
        chk("rstmid_no_ack_b", d_ack[1], 1'b0);

        // Contention from reset: fetch, data, fetch, data
        f_addr = 16'h0010; d_addr = 16'h0900; d_we = 1'b0; RAM = 16'h00C4;
        f_req[1] = 1'b1; d_req[1] = 1'b1;
        n_ack = 0; gorder = '0; both_ack = 1'b0;
        for (int c = 0; c < 40 && n_ack < 4; c++) begin
            tick();
            if (f_ack[1] || d_ack[1]) begin
                gorder[n_ack] = d_ack[1];
                both_ack = both_ack | (f_ack[1] & d_ack[1]);
                n_ack++;
            end
        end
        f_req[1] = 1'b0; d_req[1] = 1'b0;
        chk("contend_count", 16'(n_ack), 16'd4);
        chk("contend_order", gorder, 4'b1010);
        chk("contend_both", both_ack, 1'b0);
        chk("contend_f_rdata", f_rdata[1], 16'h00C4);
        chk("contend_d_rdata", d_rdata[1], 16'h00C4);
        tick();

        // Faults: illegal fetch, protected data write
        f_addr = 16'h0400; RAM = 16'h7777; f_req[1] = 1'b1;
        tick();
        chk("ffault_ack", f_ack[1], 1'b1);
        chk("ffault_flag", f_fault[1], 1'b1);
        chk("ffault_rdata", f_rdata[1], 16'h00C4);
        chk("ffault_w1", Write1[1], 1'b0);
        chk("ffault_arr1", ARr1[1], 16'h0900);
        f_req[1] = 1'b0;
        tick();
        chk("ffault_clear", {f_ack[1], f_fault[1]}, 2'b00);
        d_addr = 16'h0010; d_wdata = 16'hBEEF; d_we = 1'b1; d_req[1] = 1'b1;
        tick();
        chk("dfault_ack", d_ack[1], 1'b1);
        chk("dfault_flag", d_fault[1], 1'b1);
        chk("dfault_w1", Write1[1], 1'b0);
        chk("dfault_inputs1", Inputs1[1], 16'h00FF);
        d_req[1] = 1'b0;
        tick();
        chk("dfault_clear", {d_ack[1], d_fault[1]}, 2'b00);

        // Same write permitted when iram writes are enabled (RD_LAT = 3 instance)
        d_req[2] = 1'b1;
        lat[2] = 0;
        tick();
        chk("iram_wr_w1", Write1[2], 1'b1);
        chk("iram_wr_inputs1", Inputs1[2], 16'hBEEF);
        for (int c = 1; c < 12 && lat[2] == 0; c++) begin
            tick();
            if (d_ack[2]) begin
                lat[2] = c + 1;
                chk("iram_wr_fault", d_fault[2], 1'b0);
            end
        end
        d_req[2] = 1'b0;
        chk("iram_wr_lat", 16'(lat[2]), 16'd5);
        tick();

        // Latency sweep: data read at 0x0900 on all three instances
        d_addr = 16'h0900; d_we = 1'b0; RAM = 16'h005A; d_req = 3'b111;
        for (int i = 0; i < 3; i++) lat[i] = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                if (d_ack[i] && lat[i] == 0) begin
                    lat[i] = c + 1;
                    d_req[i] = 1'b0;
                end
            end
        end
        d_req = '0;
        chk("sweep_lat0", 16'(lat[0]), 16'd2);
        chk("sweep_lat1", 16'(lat[1]), 16'd3);
        chk("sweep_lat3", 16'(lat[2]), 16'd5);
        chk("sweep_rdata0", d_rdata[0], 16'h005A);
        chk("sweep_rdata3_hi", 16'(d_rdata[2][15:8]), 16'h0000);
        chk("sweep_rdata3", d_rdata[2], 16'h005A);
        chk("sweep_idle", busy, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
